// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and NOP constant for the pipeline stage registers
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_TWO = 2'd2;
  localparam logic [15:0] NOP = 16'h0000;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready stage register with 2-entry skid buffer and flush
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       level
);
  logic [1:0] state, state_nx;
  logic [WIDTH-1:0] main, main_nx, skid, skid_nx;
  logic in_fire, out_fire;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // state and data registers; reset and flush both return to an empty, bubble-filled stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      main <= BUBBLE;
      skid <= BUBBLE;
    end else begin
      state <= state_nx;
      main <= main_nx;
      skid <= skid_nx;
    end
  end
  // next state: head in main, overflow in skid, skid drains into main when head leaves
  always_comb begin
    state_nx = state;
    main_nx = main;
    skid_nx = skid;
    if (flush) begin
      state_nx = ST_EMPTY;
      main_nx = BUBBLE;
      skid_nx = BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          state_nx = in_fire ? ST_ONE : ST_EMPTY;
          main_nx = in_fire ? in_data : main;
        end
        ST_ONE: begin
          state_nx = (in_fire == out_fire) ? ST_ONE : in_fire ? ST_TWO : ST_EMPTY;
          main_nx = in_fire && out_fire ? in_data : out_fire ? BUBBLE : main;
          skid_nx = in_fire && !out_fire ? in_data : skid;
        end
        ST_TWO: begin
          state_nx = out_fire ? ST_ONE : ST_TWO;
          main_nx = out_fire ? skid : main;
          skid_nx = out_fire ? BUBBLE : skid;
        end
        default: begin
          state_nx = ST_EMPTY;
          main_nx = BUBBLE;
          skid_nx = BUBBLE;
        end
      endcase
    end
  end
  // outputs decode registers only, so downstream stalls never reach in_ready combinationally
  always_comb begin
    in_ready = state != ST_TWO;
    out_valid = state != ST_EMPTY;
    out_data = main;
    level = state;
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed stimulus with a scoreboard queue checked by an output monitor
module tb_pipe_skid_reg;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [1:0] level;
  logic [15:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  pipe_skid_reg #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: every downstream consume must match the oldest expected entry
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got %h expected nothing", out_data);
      end else begin
        logic [15:0] e;
        e = q.pop_front();
        if (out_data !== e) begin
          n_bad++;
          $display("FAIL out_data: got %h expected %h", out_data, e);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready %b expected 1 for %h", in_ready, d);
    end else q.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hABCD;
    out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_level", {14'd0, level}, 16'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i));
      chk("stream_level", {14'd0, level}, 16'd1);
    end
    tick(3);
    chk("stream_drained", {14'd0, level}, 16'd0);
    out_ready = 1'b0;
    send(16'h1111);
    send(16'h2222);
    chk("stall_level", {14'd0, level}, 16'd2);
    chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
    in_valid = 1'b1;
    in_data = 16'h3333;
    tick(3);
    chk("stall_hold_level", {14'd0, level}, 16'd2);
    chk("stall_hold_ready", {15'd0, in_ready}, 16'd0);
    chk("stall_hold_data", out_data, 16'h1111);
    out_ready = 1'b1;
    send(16'h3333);
    tick(3);
    chk("skid_drained", {14'd0, level}, 16'd0);
    out_ready = 1'b0;
    send(16'h00AA);
    send(16'h00BB);
    chk("flush_pre_level", {14'd0, level}, 16'd2);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h00CC;
    tick(1);
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_level", {14'd0, level}, 16'd0);
    chk("flush_out_data", out_data, 16'h0000);
    chk("flush_out_valid", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    send(16'h0005);
    chk("sim_pre_data", out_data, 16'h0005);
    out_ready = 1'b1;
    send(16'h0006);
    chk("sim_out_data", out_data, 16'h0006);
    chk("sim_level", {14'd0, level}, 16'd1);
    tick(2);
    out_ready = 1'b0;
    send(16'h00A1);
    send(16'h00A2);
    chk("rmid_pre_level", {14'd0, level}, 16'd2);
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h00A3;
    tick(1);
    reset = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("rmid_level", {14'd0, level}, 16'd0);
    chk("rmid_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rmid_out_data", out_data, 16'h0000);
    tick(3);
    send(16'h00B1);
    tick(3);
    chk("final_queue_empty", 16'(q.size()), 16'd0);
    chk("final_level", {14'd0, level}, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
